// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the pipeline stage register.
// The state encoding is used by both the skid and non-skid builds.
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bundle around one pipeline stage.
// The slave view is the stage itself; the master view is its environment.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: sticks at all ones instead of wrapping.
// Synchronous active-low reset.
module pipe_sat_cnt #(
  parameter int CNT_W = pipe_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// One-cycle pipeline register with freeze/flush and a saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry so in_ready is purely registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
`endif
  logic main_valid;
  logic stage_ready;
  logic in_fire;
  logic out_fire;
  logic stall;

  assign main_valid = (state_q != EMPTY);

`ifdef PIPE_SKID_EN
  assign stage_ready = (state_q != TWO);
`else
  assign stage_ready = !main_valid || bus.out_ready;
`endif

  // Flush also hides the held beat so a discarded beat can never fire downstream.
  assign bus.in_ready  = rst && !freeze && !flush && stage_ready;
  assign bus.out_valid = rst && !freeze && !flush && main_valid;
  assign bus.out_data  = main_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign stall    = (main_valid && !bus.out_ready) || freeze;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (freeze) begin
      state_d = state_q;
    end else if (flush) begin
      state_d = EMPTY;
      main_d  = FLUSH_VAL;
`ifdef PIPE_SKID_EN
      skid_d  = FLUSH_VAL;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
`ifdef PIPE_SKID_EN
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = bus.in_data;
`endif
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_VAL;
`ifdef PIPE_SKID_EN
      skid_q  <= FLUSH_VAL;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, hand-written corner sequences and a beat scoreboard.
module tb_pipe_stage_reg;

  localparam logic [63:0] FV = 64'hF0F0_0000_DEAD_BEEF;
`ifdef PIPE_SKID_EN
  localparam logic SK = 1'b1;
`else
  localparam logic SK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       freeze;
  logic       flush;
  logic [3:0] stall_cnt;

  int vectors;
  int miscompares;
  logic [63:0] exp_q[$];

  pipe_stage_reg_if #(.DATA_W(64)) bus ();

  pipe_stage_reg #(
    .DATA_W(64),
    .FLUSH_VAL(FV),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .flush(flush),
    .bus(bus.slave),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r, fz, fl, iv;
    logic [63:0] d;
    logic        ordy;
    logic        ov, ir;
    logic [63:0] od;
    logic [3:0]  sc;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fz, input logic fl, input logic iv,
                       input logic [63:0] d, input logic ordy);
    rst = r; freeze = fz; flush = fl;
    bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
  endtask

  task automatic to_pos;
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic do_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    to_pos;
  endtask

  // Scoreboard: accepted beats are queued, emitted beats must match in order.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got %h want no beat", bus.out_data);
      end else begin
        chk("sb_data", bus.out_data, exp_q.pop_front());
      end
    end
    if (rst && bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    if (!rst || (flush && !freeze)) exp_q.delete();
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    to_pos;
    to_pos;

    // r fz fl iv data ordy | ov ir out_data stall
    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h01, 1'b1, 1'b0, 1'b0, FV,     4'd0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h11, 1'b0, 1'b0, 1'b1, FV,     4'd0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h00, 1'b0, 1'b1, SK,   64'h11, 4'd0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h00, 1'b0, 1'b0, 1'b0, 64'h11, 4'd1};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h22, 1'b1, 1'b1, 1'b1, 64'h11, 4'd2};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 64'h33, 1'b1, 1'b0, 1'b0, 64'h22, 4'd2};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 1'b1, FV,     4'd2};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h44, 1'b1, 1'b0, 1'b0, FV,     4'd2};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h44, 1'b0, 1'b0, 1'b1, FV,     4'd3};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h55, 1'b0, 1'b0, 1'b0, 64'h44, 4'd3};
    tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 1'b1, FV,     4'd0};

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].r, tv[i].fz, tv[i].fl, tv[i].iv, tv[i].d, tv[i].ordy);
      to_neg;
      chk($sformatf("tv%0d_out_valid", i), 64'(bus.out_valid), 64'(tv[i].ov));
      chk($sformatf("tv%0d_in_ready", i),  64'(bus.in_ready),  64'(tv[i].ir));
      chk($sformatf("tv%0d_out_data", i),  bus.out_data,       tv[i].od);
      chk($sformatf("tv%0d_stall_cnt", i), 64'(stall_cnt),     64'(tv[i].sc));
      to_pos;
    end

    // Streaming at full rate, one cycle of latency; payload held once idle.
    do_reset;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, (i < 8), 64'(i + 1), 1'b1);
      to_neg;
      chk($sformatf("str%0d_out_valid", i), 64'(bus.out_valid), 64'((i >= 1) && (i <= 8)));
      chk($sformatf("str%0d_out_data", i), bus.out_data,
          (i == 0) ? FV : ((i <= 8) ? 64'(i) : 64'h8));
      chk($sformatf("str%0d_in_ready", i), 64'(bus.in_ready), 64'h1);
      to_pos;
    end
    chk("str_stall_cnt", 64'(stall_cnt), 64'h0);

    // Backpressure with two beats offered while downstream is stalled.
    do_reset;
    for (int c = 0; c < 6; c++) begin
      logic exp_ir;
      logic exp_ov;
      logic [63:0] exp_od;
      drive(1'b1, 1'b0, 1'b0, (c <= 3), (c == 0) ? 64'hA : 64'hB, (c >= 3));
      case (c)
        0:       begin exp_ir = 1'b1; exp_ov = 1'b0; exp_od = FV;    end
        1:       begin exp_ir = SK;   exp_ov = 1'b1; exp_od = 64'hA; end
        2:       begin exp_ir = 1'b0; exp_ov = 1'b1; exp_od = 64'hA; end
        3:       begin exp_ir = !SK;  exp_ov = 1'b1; exp_od = 64'hA; end
        4:       begin exp_ir = 1'b1; exp_ov = 1'b1; exp_od = 64'hB; end
        default: begin exp_ir = 1'b1; exp_ov = 1'b0; exp_od = 64'hB; end
      endcase
      to_neg;
      chk($sformatf("bp%0d_in_ready", c),  64'(bus.in_ready),  64'(exp_ir));
      chk($sformatf("bp%0d_out_valid", c), 64'(bus.out_valid), 64'(exp_ov));
      chk($sformatf("bp%0d_out_data", c),  bus.out_data,       exp_od);
      to_pos;
    end
    chk("bp_stall_cnt", 64'(stall_cnt), 64'h2);

    // Flush drops the held beat and the beat offered in the same cycle.
    do_reset;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h55, 1'b0);
    to_pos;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    to_neg;
    chk("fl_hold_data", bus.out_data, 64'h55);
    to_pos;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h66, 1'b0);
    to_neg;
    chk("fl_in_ready", 64'(bus.in_ready), 64'h0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'h0);
    to_pos;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      to_neg;
      chk($sformatf("fl_after%0d_out_valid", c), 64'(bus.out_valid), 64'h0);
      chk($sformatf("fl_after%0d_out_data", c), bus.out_data, FV);
      to_pos;
    end

    // Freeze wins over flush; the held beat survives and stalls are counted.
    do_reset;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h77, 1'b0);
    to_pos;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
      to_neg;
      chk($sformatf("fz%0d_out_valid", c), 64'(bus.out_valid), 64'h0);
      chk($sformatf("fz%0d_in_ready", c), 64'(bus.in_ready), 64'h0);
      chk($sformatf("fz%0d_stall_cnt", c), 64'(stall_cnt), 64'(c));
      to_pos;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    to_neg;
    chk("fz_rel_out_valid", 64'(bus.out_valid), 64'h1);
    chk("fz_rel_out_data", bus.out_data, 64'h77);
    chk("fz_rel_stall_cnt", 64'(stall_cnt), 64'h3);
    to_pos;
    to_neg;
    chk("fz_done_out_valid", 64'(bus.out_valid), 64'h0);
    to_pos;

    // Saturation at all ones, then reset mid-beat.
    do_reset;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h99, 1'b0);
    to_pos;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      to_pos;
    end
    to_neg;
    chk("sat_stall_cnt", 64'(stall_cnt), 64'hF);
    chk("sat_out_data", bus.out_data, 64'h99);
    to_pos;
    to_neg;
    chk("sat_hold_stall_cnt", 64'(stall_cnt), 64'hF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    to_pos;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    to_neg;
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_after_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_after_out_data", bus.out_data, FV);
    to_pos;

    chk("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width (PC + instruction).
REQ-002 SHALL have parameter FLUSH_VAL, default 0, payload value loaded on reset/flush (bubble).
REQ-003 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-006 SHALL have port freeze  input  1  hold all state, block both transfers.
REQ-007 SHALL have port flush  input  1  discard stage contents.
REQ-008 SHALL have port in_valid  input  1  upstream beat present.
REQ-009 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-010 SHALL have port in_ready  output  1  stage accepts beat this cycle.
REQ-011 SHALL have port out_valid  output  1  stage holds beat for downstream.
REQ-012 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-013 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating stall-cycle count.

Function
REQ-015 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready; data moves only on fire.
REQ-016 SHALL give latency 1 cycle (in_fire at edge N -> out_valid from N+1) and sustain 1 beat/cycle when out_ready held 1.
REQ-017 SHALL, when freeze=1, hold main/skid registers and state, force in_ready=0 and out_valid=0.
REQ-018 SHALL give freeze priority over flush; flush asserted during freeze is ignored, not remembered.
REQ-019 SHALL, on flush=1 and freeze=0, clear main and skid valid, load FLUSH_VAL into both payloads, go to EMPTY, force in_ready=0 that cycle (incoming beat dropped).
REQ-020 SHALL keep FSM states EMPTY (no beat), ONE (main valid), TWO (main+skid valid; skid build only).
REQ-021 SHALL transition EMPTY->ONE on in_fire; ONE->TWO on in_fire & !out_fire (beat to skid); ONE->ONE on in_fire & out_fire (main<=in); ONE->EMPTY on out_fire & !in_fire; TWO->ONE on out_fire (main<=skid).
REQ-022 SHALL drive out_data from main register only; beat order preserved, no beat lost or duplicated.
REQ-023 SHALL increment stall_cnt each cycle with (out_valid_internal & !out_ready) | freeze, saturating at all ones, never wrapping.
REQ-024 SHALL leave payload registers unchanged on cycles without a load (no X, no zeroing).

Reset
REQ-025 SHALL, when rst=0 at a rising edge, set state EMPTY, main/skid valid 0, payloads FLUSH_VAL, stall_cnt 0, regardless of freeze/flush/in_valid.
REQ-026 SHALL, during reset mid-transfer, drop held beats; out_valid=0 and in_ready=0 while rst=0.

Configuration
REQ-027 SHALL compile skid register and state TWO only when PIPE_SKID_EN is defined: in_ready = !skid_valid (registered, no out_ready->in_ready comb path).
REQ-028 SHALL, without PIPE_SKID_EN, omit skid storage: in_ready = !main_valid | out_ready (combinational), state TWO unreachable; all other behaviour identical.

Structure
REQ-029 SHALL place state enum (EMPTY/ONE/TWO) and default DATA_W/CNT_W constants in shared package pipe_pkg.
REQ-030 SHALL implement the saturating counter as sub-module pipe_sat_cnt (params CNT_W; ports clk, rst, inc, cnt).

Verification
REQ-031 SHALL cover streaming: in_valid=1, out_ready=1, data 0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles, one cycle later, stall_cnt=0.
REQ-032 SHALL cover backpressure (PIPE_SKID_EN): out_ready=0 while sending 0xA,0xB -> both accepted, in_ready=0 after 2nd; out_ready=1 -> 0xA then 0xB, stall_cnt equals stalled cycles.
REQ-033 SHALL cover flush: stage holds 0x55, flush=1 with in_valid=1 data 0x66 -> next cycle out_valid=0, payload FLUSH_VAL, 0x66 never emitted.
REQ-034 SHALL cover freeze+flush: hold 0x77, freeze=1 and flush=1 for 3 cycles -> after release 0x77 still emitted, stall_cnt advanced by 3.
REQ-035 SHALL cover saturation and reset: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15; rst=0 one cycle -> stall_cnt=0, out_valid=0.
